// File: rtl/ysyx_23060025_wbuf.sv
// ysyx_23060025_wbuf: one-entry dcache write buffer that drains a byte/half/word or a full line over AXI.
// Optional feature macro YSYX_23060025_WBUF_ERR_EN enables the sticky out_werr flag on non-OKAY responses.
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif

module ysyx_23060025_wbuf #(
   parameter int ADDR_WIDTH            = 32,
   parameter int CACHE_LINE_OFF_ADDR_W = `MACRO_CACHE_LINE_OFF_ADDR_W,
   localparam int CACHE_LINE_W         = (2**CACHE_LINE_OFF_ADDR_W)*8,
   localparam int BEATS                = CACHE_LINE_W/32
) (
   input  logic                    clock,
   input  logic                    reset,
   // dcache side
   input  logic                    in_pwr_req,
   input  logic [ADDR_WIDTH-1:0]   in_pwaddr,
   input  logic [CACHE_LINE_W-1:0] in_pwdata,
   input  logic [3:0]              in_pwstrb,
   input  logic [2:0]              in_pwtype,
   output logic                    in_pwrdy,
   // AXI write address
   output logic                    out_awvalid,
   input  logic                    out_awready,
   output logic [ADDR_WIDTH-1:0]   out_awaddr,
   output logic [7:0]              out_awlen,
   output logic [2:0]              out_awsize,
   // AXI write data
   output logic                    out_wvalid,
   input  logic                    out_wready,
   output logic [31:0]             out_wdata,
   output logic [3:0]              out_wstrb,
   output logic                    out_wlast,
   // AXI write response
   input  logic                    out_bvalid,
   output logic                    out_bready,
   input  logic [1:0]              out_bresp,
   output logic                    out_werr,
   // FSM state for checkers
   output logic [1:0]              dbg_state_o
);

   // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
   // every output of this block is held stable while its valid is 1 and ready is 0.

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS-1);
   localparam logic [2:0] TYPE_LINE = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CACHE_LINE_W-1:0] data_q, data_d;
   logic [3:0]              strb_q, strb_d;
   logic [2:0]              type_q, type_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;

   logic        is_line;
   logic        last_beat;
   logic [31:0] line_beat;

   assign is_line   = (type_q == TYPE_LINE);
   assign last_beat = is_line ? (beat_q == LAST_BEAT) : 1'b1;

   // Lowest 32-bit slice of the line goes out first.
   always_comb begin
      line_beat = data_q[31:0];
      for (int k = 0; k < BEATS; k++) begin
         if (beat_q == BEAT_W'(k)) line_beat = data_q[32*k +: 32];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         type_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         type_q  <= type_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      strb_d  = strb_q;
      type_d  = type_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (in_pwr_req) begin
               addr_d  = in_pwaddr;
               data_d  = in_pwdata;
               strb_d  = in_pwstrb;
               type_d  = in_pwtype;
               beat_d  = '0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (out_awready) state_d = S_DATA;
         end
         S_DATA: begin
            if (out_wready) begin
               if (last_beat) state_d = S_RESP;
               else           beat_d  = beat_q + BEAT_W'(1);
            end
         end
         S_RESP: begin
            if (out_bvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_pwrdy    = (state_q == S_IDLE);
   assign out_awvalid = (state_q == S_ADDR);
   assign out_awaddr  = addr_q;
   assign out_awlen   = is_line ? 8'(BEATS-1) : 8'd0;
   assign out_awsize  = is_line ? 3'b010 : type_q;
   assign out_wvalid  = (state_q == S_DATA);
   assign out_wdata   = is_line ? line_beat : data_q[31:0];
   assign out_wstrb   = is_line ? 4'hF : strb_q;
   assign out_wlast   = (state_q == S_DATA) && last_beat;
   assign out_bready  = (state_q == S_RESP);
   assign dbg_state_o = state_q;

`ifdef YSYX_23060025_WBUF_ERR_EN
   logic werr_q, werr_d;

   always_comb begin
      werr_d = werr_q;
      if (out_bvalid && out_bready && (out_bresp != 2'b00)) werr_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) werr_q <= 1'b0;
      else       werr_q <= werr_d;
   end

   assign out_werr = werr_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^out_bresp;
   assign out_werr     = 1'b0;
`endif

endmodule

// File: doc/ysyx_23060025_wbuf.md
YSYX_23060025_WBUF -- requirements
Module: ysyx_23060025_wbuf

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, address width; CACHE_LINE_OFF_ADDR_W, `MACRO_CACHE_LINE_OFF_ADDR_W, line offset bits. CACHE_LINE_W=(2**CACHE_LINE_OFF_ADDR_W)*8 and BEATS=CACHE_LINE_W/32 SHALL be derived.
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clock  in  1  system clock; reset  in  1  async active-high reset.
REQ-003 in_pwr_req  in  1  dcache write request, sampled only while in_pwrdy=1.
REQ-004 in_pwaddr  in  ADDR_WIDTH  write address; line-aligned for line writes.
REQ-005 in_pwdata  in  CACHE_LINE_W  write data; bits [31:0] only for single writes.
REQ-006 in_pwstrb  in  4  byte strobe; single writes only.
REQ-007 in_pwtype  in  3  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cacheline.
REQ-008 in_pwrdy  out  1  buffer empty, request accepted this cycle.
REQ-009 out_awvalid/out_awready  out/in  1  AXI AW handshake; out_awaddr  out  ADDR_WIDTH; out_awlen  out  8; out_awsize  out  3.
REQ-010 out_wvalid/out_wready  out/in  1  AXI W handshake; out_wdata  out  32; out_wstrb  out  4; out_wlast  out  1.
REQ-011 out_bvalid/out_bready  in/out  1  AXI B handshake; out_bresp  in  2  write response.
REQ-012 out_werr  out  1  sticky write-error flag (see Configuration).

Function
REQ-013 SHALL be a one-entry buffer with FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; in_pwrdy=1 only in IDLE.
REQ-014 IDLE: in_pwr_req=1 captures addr, data, strb, type into registers and moves to ADDR on the next edge; in_pwrdy drops the cycle after capture.
REQ-015 ADDR: out_awvalid=1 with registered address, held stable until out_awready=1; then DATA.
REQ-016 Line write: out_awsize=3'b010, out_awlen=BEATS-1, out_wstrb=4'hF; beat k carries line bits [32k+31:32k], lowest beat first.
REQ-017 Single write: out_awsize=in_pwtype, out_awlen=0, out_wstrb=captured strb, out_wdata=captured data[31:0].
REQ-018 DATA: out_wvalid=1; beat counter advances only on out_wvalid&out_wready; out_wlast=1 exactly on the final beat; after the last handshake, RESP.
REQ-019 Stalls (awready/wready/bvalid low for any number of cycles) SHALL hold all outputs stable; no beat skipped or repeated.
REQ-020 RESP: out_bready=1; on out_bvalid go to IDLE; in_pwrdy=1 the following cycle.
REQ-021 in_pwr_req outside IDLE SHALL be ignored and SHALL NOT corrupt captured data.
REQ-022 Beat counter SHALL be wide enough for BEATS-1 and reset to 0 on each new capture; no wrap past BEATS-1.
REQ-023 Minimum no-stall latency, capture to in_pwrdy=1: line write BEATS+3 cycles, single write 4 cycles.

Reset
REQ-024 On reset assertion, asynchronously: state=IDLE, in_pwrdy=1, out_awvalid=0, out_wvalid=0, out_wlast=0, out_bready=0, out_werr=0, beat counter=0.
REQ-025 Reset mid-transaction SHALL abandon it without completing the AXI burst; the first post-reset cycle SHALL be IDLE.

Configuration
REQ-026 Macro YSYX_23060025_WBUF_ERR_EN: defined -> out_werr sets on out_bvalid&out_bready with out_bresp!=2'b00 and holds until reset; undefined -> out_werr tied 0, out_bresp ignored. Handshake timing SHALL be identical in both builds.

Verification
REQ-027 Line write, CACHE_LINE_OFF_ADDR_W=4, addr 0x8000_0010, data 0x4444_4444_3333_3333_2222_2222_1111_1111, no stalls -> awlen=3, awsize=2, beats 0x11111111..0x44444444, wlast on beat 4, in_pwrdy after 7 cycles.
REQ-028 Byte write, addr 0x1000_0003, type 3'b000, strb 4'b1000, data 0xAB00_0000 -> awlen=0, awsize=0, one beat wdata 0xAB00_0000, wstrb 4'b1000, wlast=1.
REQ-029 Line write with awready low 3 cycles and wready toggling each cycle -> awaddr/wdata stable while stalled, exactly 4 W handshakes in order.
REQ-030 in_pwr_req pulsed with addr 0xDEAD_0000 during DATA of a write to 0x8000_0000 -> burst completes to 0x8000_0000, second request not issued.
REQ-031 Reset asserted in DATA after beat 2 -> outputs per REQ-024 immediately; subsequent write issues a fresh AW with beat counter 0.
REQ-032 With YSYX_23060025_WBUF_ERR_EN, bresp=2'b10 -> out_werr=1 and stays 1 through a later OKAY write; without macro -> out_werr=0.
